// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of imem_loader.
// master = the loader itself, slave = byte source / memory side.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  cpu_hold;
  logic                  done;
  logic                  err;

  modport master (
    input  start, byte_valid, byte_data,
    output byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err
  );

  modport slave (
    output start, byte_valid, byte_data,
    input  byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a program image (count byte, then MSB-first words) into instruction memory.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.master bus
);
  localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
  localparam int DEPTH          = 2 ** ADDR_WIDTH;
  localparam int BCW            = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    BYTES,
    WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHECK,
`endif
    FIN
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            count_q, count_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [BCW-1:0]        byte_cnt_q, byte_cnt_d;
  logic [8:0]            word_cnt_q, word_cnt_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic                  err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            xor_q, xor_d;
`endif
  logic                  byte_ready;
  logic                  wr_en;
  logic                  done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      word_q     <= '0;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      wr_addr_q  <= '0;
      err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_q     <= word_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      wr_addr_q  <= wr_addr_d;
      err_q      <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q      <= xor_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_d     = word_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    wr_addr_d  = wr_addr_q;
    err_d      = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    xor_d      = xor_q;
`endif
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    done       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          err_d      = 1'b0;
          wr_addr_d  = '0;
          word_cnt_d = '0;
          byte_cnt_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d      = '0;
`endif
          state_d    = COUNT;
        end
      end

      COUNT: begin
        byte_ready = 1'b1;
        if (bus.byte_valid) begin
          count_d = bus.byte_data;
          if (bus.byte_data == 8'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = FIN;
`endif
          end else if (int'(bus.byte_data) > DEPTH) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else begin
            state_d = BYTES;
          end
        end
      end

      BYTES: begin
        byte_ready = 1'b1;
        if (bus.byte_valid) begin
          word_d = (word_q << 8) | DATA_WIDTH'(bus.byte_data);
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d  = xor_q ^ bus.byte_data;
`endif
          if (byte_cnt_q == BCW'(BYTES_PER_WORD - 1)) begin
            byte_cnt_d = '0;
            state_d    = WRITE;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end

      // A full-depth load lets wr_addr wrap to 0 here; no write follows it.
      WRITE: begin
        wr_en      = 1'b1;
        wr_addr_d  = wr_addr_q + 1'b1;
        word_cnt_d = word_cnt_q + 1'b1;
        if (word_cnt_d == {1'b0, count_q}) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = FIN;
`endif
        end else begin
          state_d = BYTES;
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        byte_ready = 1'b1;
        if (bus.byte_valid) begin
          if (bus.byte_data != xor_q) begin
            err_d = 1'b1;
          end
          state_d = FIN;
        end
      end
`endif

      FIN: begin
        done    = ~err_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.byte_ready = byte_ready;
  assign bus.wr_en      = wr_en;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = word_q;
  assign bus.cpu_hold   = (state_q != IDLE) && (state_q != FIN);
  assign bus.done       = done;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; checksum cases compile in
// only when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;
  localparam int AW = 6;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  int acc0 = 0;

  logic [AW-1:0] log_addr [0:127];
  logic [DW-1:0] log_data [0:127];
  int            log_cyc  [0:127];
  int            log_n = 0;
  int            done_cnt = 0;
  int            hold_bad = 0;
  logic          prev_hold = 1'b0;
  logic [31:0]   img [0:63];

  always @(posedge clk) cyc <= cyc + 1;

  // Write/done monitor sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.wr_en && log_n < 128) begin
      log_addr[log_n] = bus.wr_addr;
      log_data[log_n] = bus.wr_data;
      log_cyc[log_n]  = cyc;
      log_n++;
    end
    if (bus.done) begin
      done_cnt++;
      if (bus.cpu_hold || !prev_hold) hold_bad++;
    end
    prev_hold = bus.cpu_hold;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic clear_log();
    log_n    = 0;
    done_cnt = 0;
    hold_bad = 0;
  endtask

  task automatic check_zero(input string pfx);
    checkOutput({pfx, "_byte_ready"}, 64'(bus.byte_ready), 64'd0);
    checkOutput({pfx, "_wr_en"},      64'(bus.wr_en),      64'd0);
    checkOutput({pfx, "_wr_addr"},    64'(bus.wr_addr),    64'd0);
    checkOutput({pfx, "_wr_data"},    64'(bus.wr_data),    64'd0);
    checkOutput({pfx, "_cpu_hold"},   64'(bus.cpu_hold),   64'd0);
    checkOutput({pfx, "_done"},       64'(bus.done),       64'd0);
    checkOutput({pfx, "_err"},        64'(bus.err),        64'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall);
    logic rdy;
    bit   acc;
    acc = 1'b0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      rdy = bus.byte_ready;
      @(posedge clk); #1;
      if (rdy) acc = 1'b1;
    end
    if (!acc) checkOutput("byte_accept_timeout", 64'd0, 64'd1);
    last_acc       = cyc;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'hEE;
    repeat (stall) begin
      @(posedge clk); #1;
    end
  endtask

  // cs_mode: 0 = no checksum byte, 1 = correct, 2 = corrupted.
  task automatic run_load(input logic [7:0] cnt, input int nw, input int stall,
                          input int cs_mode, input bit hammer);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    applyStimulus();
    send_byte(cnt, stall);
    for (int w = 0; w < nw; w++) begin
      for (int k = 3; k >= 0; k--) begin
        b = img[w][8*k +: 8];
        x = x ^ b;
        bus.start = hammer && (k == 0);
        send_byte(b, stall);
        bus.start = 1'b0;
        if (w == 0 && k == 0) acc0 = last_acc;
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (cs_mode != 0) send_byte((cs_mode == 1) ? x : (x ^ 8'h01), stall);
`else
    if (cs_mode > 2) x = 8'h00;
`endif
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    int bad;
    bus.start      = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    reset          = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst");
    reset = 1'b0;
    @(posedge clk); #1;

    $display("[TB] two-word load, no stalls");
    clear_log();
    img[0] = 32'h12345678;
    img[1] = 32'hAABBCCDD;
    run_load(8'h02, 2, 0, 1, 1'b0);
    checkOutput("t1_nwr",  64'(log_n), 64'd2);
    checkOutput("t1_a0",   64'(log_addr[0]), 64'd0);
    checkOutput("t1_d0",   64'(log_data[0]), 64'h12345678);
    checkOutput("t1_a1",   64'(log_addr[1]), 64'd1);
    checkOutput("t1_d1",   64'(log_data[1]), 64'hAABBCCDD);
    checkOutput("t1_lat",  64'(log_cyc[0]), 64'(acc0));
    checkOutput("t1_done", 64'(done_cnt), 64'd1);
    checkOutput("t1_hold_edge", 64'(hold_bad), 64'd0);
    checkOutput("t1_err",  64'(bus.err), 64'd0);
    checkOutput("t1_hold", 64'(bus.cpu_hold), 64'd0);

    $display("[TB] two-word load, 3-cycle stalls");
    clear_log();
    run_load(8'h02, 2, 3, 1, 1'b0);
    checkOutput("t2_nwr",  64'(log_n), 64'd2);
    checkOutput("t2_d0",   64'(log_data[0]), 64'h12345678);
    checkOutput("t2_a1",   64'(log_addr[1]), 64'd1);
    checkOutput("t2_d1",   64'(log_data[1]), 64'hAABBCCDD);
    checkOutput("t2_lat",  64'(log_cyc[0]), 64'(acc0));
    checkOutput("t2_done", 64'(done_cnt), 64'd1);
    checkOutput("t2_err",  64'(bus.err), 64'd0);

    $display("[TB] oversize count");
    clear_log();
    run_load(8'h41, 0, 0, 0, 1'b0);
    checkOutput("t3_nwr",  64'(log_n), 64'd0);
    checkOutput("t3_done", 64'(done_cnt), 64'd0);
    checkOutput("t3_err",  64'(bus.err), 64'd1);
    checkOutput("t3_hold", 64'(bus.cpu_hold), 64'd0);
    applyStimulus();
    checkOutput("t3_err_clr", 64'(bus.err), 64'd0);
    checkOutput("t3_hold_on", 64'(bus.cpu_hold), 64'd1);
    send_byte(8'h00, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    repeat (4) @(posedge clk);
    #1;
    checkOutput("t3_n0_done", 64'(done_cnt), 64'd1);
    checkOutput("t3_n0_nwr",  64'(log_n), 64'd0);
    checkOutput("t3_n0_err",  64'(bus.err), 64'd0);

    $display("[TB] reset in mid-load");
    clear_log();
    img[0] = 32'h11223344;
    img[1] = 32'h55667788;
    img[2] = 32'h99AABBCC;
    applyStimulus();
    send_byte(8'h03, 0);
    for (int k = 3; k >= 0; k--) send_byte(img[0][8*k +: 8], 0);
    send_byte(8'h55, 1);
    send_byte(8'h66, 0);
    checkOutput("t4_pre_nwr",  64'(log_n), 64'd1);
    checkOutput("t4_pre_hold", 64'(bus.cpu_hold), 64'd1);
    reset = 1'b1;
    #1;
    check_zero("t4_rst");
    @(posedge clk); #1;
    reset = 1'b0;
    clear_log();
    run_load(8'h03, 3, 1, 1, 1'b0);
    checkOutput("t4_nwr", 64'(log_n), 64'd3);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("t4_a%0d", i), 64'(log_addr[i]), 64'(i));
      checkOutput($sformatf("t4_d%0d", i), 64'(log_data[i]), 64'(img[i]));
    end
    checkOutput("t4_done", 64'(done_cnt), 64'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    $display("[TB] checksum good and bad");
    clear_log();
    img[0] = 32'h01020304;
    run_load(8'h01, 1, 0, 1, 1'b0);
    checkOutput("t5_good_done", 64'(done_cnt), 64'd1);
    checkOutput("t5_good_err",  64'(bus.err), 64'd0);
    clear_log();
    run_load(8'h01, 1, 0, 2, 1'b0);
    checkOutput("t5_bad_err",  64'(bus.err), 64'd1);
    checkOutput("t5_bad_done", 64'(done_cnt), 64'd0);
    checkOutput("t5_bad_nwr",  64'(log_n), 64'd1);
    checkOutput("t5_bad_a0",   64'(log_addr[0]), 64'd0);
    checkOutput("t5_bad_d0",   64'(log_data[0]), 64'h01020304);
`endif

    $display("[TB] full-depth load with start pulses");
    clear_log();
    for (int i = 0; i < 64; i++) begin
      img[i] = {8'(i), 8'(~i), 8'(i * 3), 8'(i ^ 32'h5A)};
    end
    run_load(8'h40, 64, 0, 1, 1'b1);
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (log_addr[i] !== AW'(i) || log_data[i] !== img[i]) bad++;
    end
    checkOutput("t6_nwr",     64'(log_n), 64'd64);
    checkOutput("t6_bad",     64'(bad), 64'd0);
    checkOutput("t6_done",    64'(done_cnt), 64'd1);
    checkOutput("t6_err",     64'(bus.err), 64'd0);
    checkOutput("t6_addr",    64'(bus.wr_addr), 64'd0);
    checkOutput("t6_hold",    64'(bus.cpu_hold), 64'd0);
    checkOutput("t6_hold_edge", 64'(hold_bad), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side companion to the instruction memory: receives a program image as a byte stream and writes it into instruction memory word by word at sequential addresses from 0.
- Replaces the simulation-only file bootstrap with a runtime load path.
- Holds the CPU in reset while loading.
- Sits between a byte source (UART receiver or testbench) and the instruction memory write port.

Parameters:
- ADDR_WIDTH, 6, instruction memory address width; depth is 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, instruction word width; must be a multiple of 8; BYTES_PER_WORD = DATA_WIDTH/8.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; ignored unless the block is in IDLE.
- byte_valid  input  1  byte_data holds a valid byte.
- byte_data  input  8  incoming image byte.
- byte_ready  output  1  loader accepts byte_data this cycle; a byte transfers when byte_valid and byte_ready are both 1.
- wr_en  output  1  instruction memory write strobe, one cycle per word.
- wr_addr  output  ADDR_WIDTH  word address for the write.
- wr_data  output  DATA_WIDTH  word to write.
- cpu_hold  output  1  high from start until the load completes; drives the CPU/PC reset.
- done  output  1  one-cycle pulse when a load completes successfully.
- err  output  1  sticky error flag; cleared by reset or by the next accepted start.

Behaviour:
- Reset values: byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=0, done=0, err=0, state=IDLE, word counter=0, byte counter=0.
- Image format:
  - First byte is N, the number of words (0..255).
  - Then N words, each sent most significant byte first.
  - With CHECKSUM_EN, one checksum byte follows the last word.
- States: IDLE, COUNT, BYTES, WRITE, CHECK, FIN.
- IDLE: byte_ready=0. On start: cpu_hold<=1, err<=0, wr_addr<=0, go to COUNT.
- COUNT: byte_ready=1. On transfer, latch N.
  - N==0: go to CHECK if CHECKSUM_EN is defined, else FIN.
  - N>2**ADDR_WIDTH: err<=1, go to FIN; no writes are issued.
  - Otherwise go to BYTES.
- BYTES: byte_ready=1. Each transfer shifts the byte into the word register from the LSB end (word <= {word[DATA_WIDTH-9:0], byte}). After BYTES_PER_WORD transfers, go to WRITE.
- WRITE: byte_ready=0. wr_en=1 for exactly one cycle with the assembled word and the current wr_addr.
  - Write latency: wr_en is asserted in the cycle after the clock edge that accepts a word's final byte.
  - Next cycle: wr_addr increments and the word counter increments.
  - If words written == N, go to CHECK (CHECKSUM_EN) or FIN; else return to BYTES.
- FIN: done=1 for one cycle, only if err==0. cpu_hold<=0. Go to IDLE.
- wr_addr never wraps during a load: N is bounded by the depth check. After the last word of a full-depth load, wr_addr wraps to 0 harmlessly and no further write is issued.
- byte_valid while byte_ready=0: the byte is not consumed; the source must hold it.
- start outside IDLE is ignored. start and reset in the same cycle: reset wins.
- Reset mid-load: immediate return to reset values. Memory contents already written are left as they are.
- Stall tolerance: any number of byte_valid=0 cycles may occur between bytes without affecting the result.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined: a running XOR of all data bytes (not the count byte) is kept.
  - State CHECK (byte_ready=1) accepts one checksum byte.
  - On mismatch: err<=1. Words already written stay written.
  - Then go to FIN.
- Not defined: CHECK state and XOR register are absent; FIN follows the last WRITE (or COUNT when N==0) directly.

Test Plan:
- Reset, then start with bytes 02, 12 34 56 78, AA BB CC DD, no stalls:
  - wr_en at addr 0 with data 0x12345678, then at addr 1 with data 0xAABBCCDD.
  - done pulses once; cpu_hold falls in the same cycle as done rises; err=0.
- Same image with byte_valid low for 3 cycles between every byte: identical writes and done; no byte is lost or duplicated.
- Count byte 0x41 (65 > 64): err=1, zero wr_en pulses, no done, cpu_hold returns to 0; the next start clears err.
- Assert reset after the 2nd byte of word 1 in a 3-word load:
  - All outputs return to 0 within the reset cycle.
  - A fresh start then loads correctly from addr 0.
- With IMEM_LOADER_CHECKSUM_EN, image 01, 01 02 03 04:
  - Checksum byte 04: done=1, err=0.
  - Checksum byte 05: err=1, no done; word 0x01020304 is still written at addr 0.
- Count byte 0x40 with 64 words: 64 wr_en pulses at addrs 0..63, then done; start pulses during the load are ignored.
